// File: rtl/ahb_lite_master_arbiter_if.sv
// rtl/ahb_lite_master_arbiter_if.sv - signals between two AHB-Lite masters, the arbiter and the slave mux
interface ahb_lite_master_arbiter_if;
   logic [31:0] M0_HADDR;
   logic [1:0]  M0_HTRANS;
   logic        M0_HWRITE;
   logic [2:0]  M0_HSIZE;
   logic [31:0] M0_HWDATA;
   logic        M0_HBUSREQ;
   logic        M0_HLOCK;
   logic        M0_HGRANT;

   logic [31:0] M1_HADDR;
   logic [1:0]  M1_HTRANS;
   logic        M1_HWRITE;
   logic [2:0]  M1_HSIZE;
   logic [31:0] M1_HWDATA;
   logic        M1_HBUSREQ;
   logic        M1_HLOCK;
   logic        M1_HGRANT;

   logic        HREADY;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HMASTER;
   logic        HMASTLOCK;

   // arbiter side: takes both masters' requests, drives grants and the shared bus
   modport slave (
      input  M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HWDATA, M0_HBUSREQ, M0_HLOCK,
      input  M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HWDATA, M1_HBUSREQ, M1_HLOCK,
      input  HREADY,
      output M0_HGRANT, M1_HGRANT,
      output HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HMASTER, HMASTLOCK
   );

   // master/bus side: drives requests and ready, observes grants and the shared bus
   modport master (
      output M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HWDATA, M0_HBUSREQ, M0_HLOCK,
      output M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HWDATA, M1_HBUSREQ, M1_HLOCK,
      output HREADY,
      input  M0_HGRANT, M1_HGRANT,
      input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HMASTER, HMASTLOCK
   );
endinterface

// File: rtl/ahb_lite_master_arbiter.sv
// rtl/ahb_lite_master_arbiter.sv - two-master AHB-Lite arbiter with address/data phase muxing
module ahb_lite_master_arbiter #(
   parameter int MAX_BEATS      = 16,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                    HCLK,
   input  logic                    HRESET,
   ahb_lite_master_arbiter_if.slave bus
);
   localparam int            CW      = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);
   localparam logic          DEF_M   = (DEFAULT_MASTER != 0);

   logic          g;        // granted master
   logic          a;        // address-phase owner
   logic          d;        // data-phase owner
   logic          l;        // current address phase is locked
   logic [CW-1:0] cnt;      // beats taken by g while the other master waits
   logic          next_g;
   logic          own_req;
   logic          own_lock;
   logic          oth_req;

   assign own_req  = g ? bus.M1_HBUSREQ : bus.M0_HBUSREQ;
   assign own_lock = g ? bus.M1_HLOCK   : bus.M0_HLOCK;
   assign oth_req  = g ? bus.M0_HBUSREQ : bus.M1_HBUSREQ;

   // Next grant: a locked owner is never pre-empted; otherwise the owner keeps
   // the bus until the waiting master has sat through MAX_BEATS beats.
   always_comb begin
      next_g = DEF_M;
      if (own_req && own_lock) begin
         next_g = g;
      end else if (own_req && (!oth_req || cnt < CNT_MAX)) begin
         next_g = g;
      end else if (oth_req) begin
         next_g = ~g;
      end
   end

   // Grant/phase pipeline and fairness counter, all advanced only on accepted edges
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         g   <= DEF_M;
         a   <= DEF_M;
         d   <= DEF_M;
         l   <= 1'b0;
         cnt <= '0;
      end else if (bus.HREADY) begin
         d <= a;
         a <= g;
         l <= own_lock & own_req;
         g <= next_g;
         if (next_g != g) begin
            cnt <= '0;
         end else if (bus.HTRANS[1] && oth_req && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign bus.M0_HGRANT = ~g;
   assign bus.M1_HGRANT = g;
   assign bus.HMASTER   = a;
   assign bus.HMASTLOCK = l;

   assign bus.HADDR  = a ? bus.M1_HADDR  : bus.M0_HADDR;
   assign bus.HTRANS = a ? bus.M1_HTRANS : bus.M0_HTRANS;
   assign bus.HWRITE = a ? bus.M1_HWRITE : bus.M0_HWRITE;
   assign bus.HSIZE  = a ? bus.M1_HSIZE  : bus.M0_HSIZE;
   assign bus.HWDATA = d ? bus.M1_HWDATA : bus.M0_HWDATA;
endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// tb/tb_ahb_lite_master_arbiter.sv - self-checking bench for ahb_lite_master_arbiter
module tb_ahb_lite_master_arbiter;
   localparam int MAXB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ahb_lite_master_arbiter_if bus_if ();

   ahb_lite_master_arbiter #(.MAX_BEATS(MAXB), .DEFAULT_MASTER(0)) dut (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus_if)
   );

   // per-master stimulus, indexed by master number
   bit          rq [2];
   bit          lk [2];
   logic [1:0]  tr [2];
   logic [31:0] ad [2];
   logic [31:0] wd [2];
   logic        wr [2];
   logic [2:0]  sz [2];
   bit          rdy;

   // reference model: granted master, owners of the two pipeline phases, lock, waiting beats
   int mg;
   int mpipe [2];
   bit mlock;
   int mbeats;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      bus_if.M0_HADDR   = ad[0];  bus_if.M1_HADDR   = ad[1];
      bus_if.M0_HTRANS  = tr[0];  bus_if.M1_HTRANS  = tr[1];
      bus_if.M0_HWRITE  = wr[0];  bus_if.M1_HWRITE  = wr[1];
      bus_if.M0_HSIZE   = sz[0];  bus_if.M1_HSIZE   = sz[1];
      bus_if.M0_HWDATA  = wd[0];  bus_if.M1_HWDATA  = wd[1];
      bus_if.M0_HBUSREQ = rq[0];  bus_if.M1_HBUSREQ = rq[1];
      bus_if.M0_HLOCK   = lk[0];  bus_if.M1_HLOCK   = lk[1];
      bus_if.HREADY     = rdy;
   endtask

   function automatic int pick();
      int other = 1 - mg;
      if (rq[mg] && lk[mg]) return mg;
      if (rq[mg] && (!rq[other] || mbeats < MAXB)) return mg;
      if (rq[other]) return other;
      return 0;
   endfunction

   task automatic model_edge();
      int nxt;
      if (rst) begin
         mg = 0; mpipe[0] = 0; mpipe[1] = 0; mlock = 0; mbeats = 0;
      end else if (rdy) begin
         nxt = pick();
         if (nxt != mg) mbeats = 0;
         else if (tr[mpipe[0]][1] && rq[1 - mg] && mbeats < MAXB) mbeats++;
         mlock    = rq[mg] && lk[mg];
         mpipe[1] = mpipe[0];
         mpipe[0] = mg;
         mg       = nxt;
      end
   endtask

   task automatic step();
      drive();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model();
      check("rnd_grant0",    {31'd0, bus_if.M0_HGRANT}, {31'd0, mg == 0});
      check("rnd_grant1",    {31'd0, bus_if.M1_HGRANT}, {31'd0, mg == 1});
      check("rnd_hmaster",   {31'd0, bus_if.HMASTER},   mpipe[0]);
      check("rnd_hmastlock", {31'd0, bus_if.HMASTLOCK}, {31'd0, mlock});
      check("rnd_haddr",     bus_if.HADDR,              ad[mpipe[0]]);
      check("rnd_htrans",    {30'd0, bus_if.HTRANS},    {30'd0, tr[mpipe[0]]});
      check("rnd_hwrite",    {31'd0, bus_if.HWRITE},    {31'd0, wr[mpipe[0]]});
      check("rnd_hsize",     {29'd0, bus_if.HSIZE},     {29'd0, sz[mpipe[0]]});
      check("rnd_hwdata",    bus_if.HWDATA,             wd[mpipe[1]]);
   endtask

   task automatic set_req(input bit r0, input bit l0, input bit r1, input bit l1);
      rq[0] = r0; lk[0] = l0; rq[1] = r1; lk[1] = l1;
   endtask

   typedef struct {
      bit         rst;
      bit         r0, l0, r1, l1, rdy;
      logic [1:0] t0, t1;
      bit         e_g1, e_hm, e_wd, e_lk;
   } vec_t;

   vec_t tbl [17];
   bit   pat [8];

   initial begin
      int acc;

      // handover, park, wait-stated handover, lock flag, reset while not ready
      //           rst r0 l0 r1 l1 rdy t0    t1     g1 hm wd lk
      tbl[0]  = '{0, 0, 0, 1, 0, 1, 2'd0, 2'd0,  1, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 1, 0, 1, 2'd0, 2'd2,  1, 1, 0, 0};
      tbl[2]  = '{0, 0, 0, 1, 0, 1, 2'd0, 2'd2,  1, 1, 1, 0};
      tbl[3]  = '{0, 0, 0, 0, 0, 1, 2'd0, 2'd0,  0, 1, 1, 0};
      tbl[4]  = '{0, 0, 0, 0, 0, 1, 2'd0, 2'd0,  0, 0, 1, 0};
      tbl[5]  = '{0, 0, 0, 0, 0, 1, 2'd0, 2'd0,  0, 0, 0, 0};
      tbl[6]  = '{0, 0, 0, 1, 0, 0, 2'd0, 2'd0,  0, 0, 0, 0};
      tbl[7]  = '{0, 0, 0, 1, 0, 0, 2'd0, 2'd0,  0, 0, 0, 0};
      tbl[8]  = '{0, 0, 0, 1, 0, 0, 2'd0, 2'd0,  0, 0, 0, 0};
      tbl[9]  = '{0, 0, 0, 1, 0, 1, 2'd0, 2'd0,  1, 0, 0, 0};
      tbl[10] = '{0, 0, 0, 1, 0, 0, 2'd0, 2'd2,  1, 0, 0, 0};
      tbl[11] = '{0, 0, 0, 1, 0, 1, 2'd0, 2'd2,  1, 1, 0, 0};
      tbl[12] = '{0, 0, 0, 1, 0, 0, 2'd0, 2'd2,  1, 1, 0, 0};
      tbl[13] = '{0, 0, 0, 1, 0, 1, 2'd0, 2'd2,  1, 1, 1, 0};
      tbl[14] = '{0, 0, 0, 1, 1, 1, 2'd0, 2'd2,  1, 1, 1, 1};
      tbl[15] = '{0, 1, 0, 1, 1, 1, 2'd0, 2'd2,  1, 1, 1, 1};
      tbl[16] = '{1, 1, 0, 1, 1, 0, 2'd0, 2'd2,  0, 0, 0, 0};

      ad[0] = 32'h0000_1000; ad[1] = 32'h0000_2000;
      wd[0] = 32'hA0A0_A0A0; wd[1] = 32'hB1B1_B1B1;
      wr[0] = 1'b1;          wr[1] = 1'b0;
      sz[0] = 3'd2;          sz[1] = 3'd1;
      tr[0] = 2'd0;          tr[1] = 2'd0;
      set_req(0, 0, 0, 0);
      rdy = 1'b1;

      // reset, then idle
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("reset_grant0",    {31'd0, bus_if.M0_HGRANT}, 32'd1);
      check("reset_grant1",    {31'd0, bus_if.M1_HGRANT}, 32'd0);
      check("reset_hmaster",   {31'd0, bus_if.HMASTER},   32'd0);
      check("reset_hmastlock", {31'd0, bus_if.HMASTLOCK}, 32'd0);
      check("reset_haddr",     bus_if.HADDR,              32'h0000_1000);

      for (int i = 0; i < 17; i++) begin
         rst = tbl[i].rst;
         set_req(tbl[i].r0, tbl[i].l0, tbl[i].r1, tbl[i].l1);
         rdy   = tbl[i].rdy;
         tr[0] = tbl[i].t0;
         tr[1] = tbl[i].t1;
         step();
         check($sformatf("vec%0d_grant0", i),    {31'd0, bus_if.M0_HGRANT}, {31'd0, !tbl[i].e_g1});
         check($sformatf("vec%0d_grant1", i),    {31'd0, bus_if.M1_HGRANT}, {31'd0, tbl[i].e_g1});
         check($sformatf("vec%0d_hmaster", i),   {31'd0, bus_if.HMASTER},   {31'd0, tbl[i].e_hm});
         check($sformatf("vec%0d_hmastlock", i), {31'd0, bus_if.HMASTLOCK}, {31'd0, tbl[i].e_lk});
         check($sformatf("vec%0d_haddr", i),     bus_if.HADDR,              ad[tbl[i].e_hm]);
         check($sformatf("vec%0d_htrans", i),    {30'd0, bus_if.HTRANS},    {30'd0, tr[tbl[i].e_hm]});
         check($sformatf("vec%0d_hwdata", i),    bus_if.HWDATA,             wd[tbl[i].e_wd]);
      end
      rst = 1'b0;

      // fairness cap with wait states: switch after MAXB counted beats, counter frozen while not ready
      rdy = 1'b1;
      set_req(0, 0, 0, 0);
      tr[0] = 2'd0; tr[1] = 2'd0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      pat[0] = 1; pat[1] = 1; pat[2] = 0; pat[3] = 0;
      pat[4] = 0; pat[5] = 1; pat[6] = 1; pat[7] = 1;
      set_req(1, 0, 1, 0);
      tr[0] = 2'd2;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         rdy = pat[i];
         step();
         tr[0] = 2'd3;
         if (pat[i]) acc++;
         check($sformatf("fair%0d_grant1", i), {31'd0, bus_if.M1_HGRANT}, {31'd0, acc > MAXB});
         check($sformatf("fair%0d_cnt", i),    {29'd0, dut.cnt},          (acc > MAXB) ? 32'd0 : acc);
      end
      rdy = 1'b1;
      step();
      check("fair_hmaster", {31'd0, bus_if.HMASTER}, 32'd1);

      // lock: M0 keeps the bus for 20 beats despite M1 waiting, releases on HLOCK drop
      rst = 1'b1;
      set_req(0, 0, 0, 0);
      step();
      rst = 1'b0;
      set_req(1, 1, 1, 0);
      tr[0] = 2'd2;
      for (int i = 0; i < 20; i++) begin
         step();
         tr[0] = 2'd3;
         check($sformatf("lock%0d_grant0", i),    {31'd0, bus_if.M0_HGRANT}, 32'd1);
         check($sformatf("lock%0d_hmastlock", i), {31'd0, bus_if.HMASTLOCK}, 32'd1);
      end
      set_req(1, 0, 1, 0);
      step();
      check("unlock_grant1", {31'd0, bus_if.M1_HGRANT}, 32'd1);

      // reset while M1 owns a locked data phase
      set_req(0, 0, 1, 1);
      tr[1] = 2'd2;
      step();
      check("m1_hmaster", {31'd0, bus_if.HMASTER}, 32'd1);
      step();
      check("m1_hwdata",    bus_if.HWDATA,             wd[1]);
      check("m1_hmastlock", {31'd0, bus_if.HMASTLOCK}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_hmaster",   {31'd0, bus_if.HMASTER},   32'd0);
      check("midrst_grant0",    {31'd0, bus_if.M0_HGRANT}, 32'd1);
      check("midrst_cnt",       {29'd0, dut.cnt},          32'd0);
      check("midrst_hmastlock", {31'd0, bus_if.HMASTLOCK}, 32'd0);
      check("midrst_hwdata",    bus_if.HWDATA,             wd[0]);

      // randomized traffic against the reference model
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 400; i++) begin
         for (int m = 0; m < 2; m++) begin
            rq[m] = ($urandom_range(0, 3) != 0);
            lk[m] = ($urandom_range(0, 3) == 0);
            tr[m] = 2'($urandom_range(0, 3));
            ad[m] = $urandom;
            wd[m] = $urandom;
            wr[m] = 1'($urandom_range(0, 1));
            sz[m] = 3'($urandom_range(0, 2));
         end
         rdy = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 63) == 0);
         step();
         check_model();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ahb_lite_master_arbiter.md
# ahb_lite_master_arbiter

Two-master AHB-Lite bus arbiter and multiplexer. It lets a second bus master, such as a DMA engine, share the system AHB-Lite bus with the NfiVe32 CPU, replacing the tied-off `HGRANT=1` / `HBUSREQ=1` single-master hookup. It sits between both masters and the AHB-Lite system slave mux:

- Masters send requests and receive grants through this block.
- The block muxes address/control in the address phase and `HWDATA` in the data phase.
- `HREADY` and `HRDATA` are broadcast from the bus to both masters directly, not through this block.

## Interface

Parameters:
- `MAX_BEATS`, default 16: accepted transfers the owner may perform while the other master is waiting, before a forced handover. Must be ≥1.
- `DEFAULT_MASTER`, default 0: master that is granted out of reset and when no master is requesting (parking).

Ports:
- `HCLK`  in  1  — bus clock. The only clock.
- `HRESET`  in  1  — synchronous, active-high reset.
- `Mx_HADDR`  in  32  — master x address (x = 0: CPU, x = 1: DMA).
- `Mx_HTRANS`  in  2  — master x transfer type.
- `Mx_HWRITE`  in  1  — master x write.
- `Mx_HSIZE`  in  3  — master x size.
- `Mx_HWDATA`  in  32  — master x write data.
- `Mx_HBUSREQ`  in  1  — master x bus request.
- `Mx_HLOCK`  in  1  — master x locked-sequence request.
- `Mx_HGRANT`  out  1  — grant to master x.
- `HREADY`  in  1  — bus ready from the slave mux.
- `HADDR`  out  32  — muxed address to the bus.
- `HTRANS`  out  2  — muxed transfer type.
- `HWRITE`  out  1  — muxed write.
- `HSIZE`  out  3  — muxed size.
- `HWDATA`  out  32  — muxed write data.
- `HMASTER`  out  1  — current address-phase owner.
- `HMASTLOCK`  out  1  — current address phase is locked.

## Operation

State registers:
- `g`: granted master (drives `Mx_HGRANT`).
- `a`: address-phase owner.
- `d`: data-phase owner.
- `l`: lock flag.
- `cnt`: beat counter, width `$clog2(MAX_BEATS+1)`, saturating at `MAX_BEATS`.

Muxing:
- `HADDR`, `HTRANS`, `HWRITE` and `HSIZE` select master `a`.
- `HWDATA` selects master `d`.
- `HMASTER = a`, `HMASTLOCK = l`.
- `M0_HGRANT = (g==0)`, `M1_HGRANT = (g==1)`.
- The inputs of the non-owner master are ignored completely.

Arbitration is evaluated every cycle but takes effect only on edges where `HREADY=1`. Let `o = g` and `p = !g`. Next grant, in priority order:
1. `o` requesting and `Mo_HLOCK=1` → keep `o`. A locked master is never pre-empted, even when `cnt` has saturated.
2. `o` requesting and (`p` not requesting, or `cnt < MAX_BEATS`) → keep `o`.
3. `p` requesting → switch to `p`.
4. Neither master requesting → `DEFAULT_MASTER`.

On an `HREADY=1` edge:
- `d <= a`
- `a <= g`
- `l <= Mg_HLOCK & Mg_HBUSREQ`
- `g <= next`

Counter:
- Cleared on any edge where `g` changes.
- Otherwise, on an `HREADY=1` edge, increments when `HTRANS[1]=1` (NONSEQ/SEQ) and `Mp_HBUSREQ=1`.
- Holds when `HREADY=0`.

A forced handover may end a burst early. The losing master observes `HGRANT` low and rebuilds the burst later with NONSEQ, per AHB rules.

## Timing

- Reset values: `g = a = d = DEFAULT_MASTER`, `l = 0`, `cnt = 0`.
  - `M0_HGRANT = 1` and `M1_HGRANT = 0` (for the default `DEFAULT_MASTER = 0`).
  - `HMASTER = DEFAULT_MASTER`, `HMASTLOCK = 0`.
  - Bus outputs combinationally follow the default master's inputs.
- Handover latency, request to first address phase: with `HREADY` held at 1, a request seen at edge N gives `HGRANT` at N+1 and address-phase ownership at N+2. Each `HREADY=0` cycle adds one cycle.
- `HWDATA` switches exactly one `HREADY`-qualified edge after `HMASTER` switches. No bubble is inserted.
- While `HREADY=0`, `g`, `a`, `d`, `l` and `cnt` all hold; `Mx_HGRANT` is stable.
- If both masters request simultaneously from a parked idle state, the current `g` keeps the bus (rule 2).
- A reset asserted mid-transfer returns all state to reset values on that edge regardless of `HREADY`. Any pending data phase is abandoned.
- No combinational path from `HREADY` to `Mx_HGRANT`. All grant outputs come straight from registers.

## Test plan

- Reset, then idle: `HRESET=1` for 2 cycles → `M0_HGRANT=1`, `M1_HGRANT=0`, `HMASTER=0`, `HMASTLOCK=0`. With `M0_HADDR=0x1000`, `HADDR=0x1000`.
- Simple handover: M0 idle (`HBUSREQ=0`), M1 raises `HBUSREQ` at edge N with `HREADY=1` → `M1_HGRANT=1` at N+1, `HMASTER=1` and `HADDR=M1_HADDR` at N+2, `HWDATA=M1_HWDATA` at N+3. M1 drops its request → bus parks on M0 two edges later.
- Fairness cap: M0 streams SEQ writes with a continuous request, M1 requests from the start, `MAX_BEATS=4` → grant moves to M1 after M0's 4th accepted beat. `cnt` is 0 after the switch.
- Lock: M0 requests with `HLOCK=1` and M1 requests for 20 beats → M0 keeps the grant throughout and `HMASTLOCK=1` during M0's address phases. M0 drops `HLOCK` → grant switches at the next `HREADY=1` edge.
- Wait states: insert `HREADY=0` for 3 cycles during a handover → `HGRANT`, `HMASTER` and `HWDATA` selection freeze. The switch completes on the first `HREADY=1` edge, and `cnt` does not advance during the wait.
- Reset mid-transfer: with M1 owning a data phase, `HRESET=1` for 1 cycle → next cycle `HMASTER=0`, `M0_HGRANT=1`, `cnt=0`, `HMASTLOCK=0`.
